flit_injector: RTL and testbench

//  Buffered packet injector: accepts a flit stream from a simulation-side parser
//  (valid/ready) and drives one external credit-based NoC injection port of the

---
 rtl/flit_injector_pkg.sv | 20 ++
 rtl/flit_fifo.sv | 71 +++++++
 rtl/flit_injector.sv | 129 ++++++++++++
 tb/tb_flit_injector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/flit_injector_pkg.sv
// ============================================================================
// Module   : PhiversPkg
// Purpose  : Types shared by the flit injector and its sub-blocks.
//            inj_state_t is the packet-framing state: the flit at the FIFO
//            head is either a header, a size flit or a payload flit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package PhiversPkg;

    typedef enum logic [1:0] {
        INJ_HEADER  = 2'd0,
        INJ_SIZE    = 2'd1,
        INJ_PAYLOAD = 2'd2
    } inj_state_t;

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// ============================================================================
// Module   : flit_fifo
// Purpose  : Synchronous FIFO with registered storage and a combinational
//            head read. A push into a full FIFO or a pop from an empty FIFO
//            is ignored.
// Ports    : clk_i   clock
//            rst_i   synchronous active-high reset (flushes the FIFO)
//            push_i  write data_i this cycle
//            data_i  write data
//            pop_i   discard the head entry this cycle
//            full_o  no free entry
//            empty_o no valid entry
//            head_o  oldest entry (undefined content when empty)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_fifo #(
    parameter int unsigned FLIT_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [FLIT_SIZE-1:0] head_o
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

    logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]      wr_ptr_q;
    logic [ADDR_W:0]      rd_ptr_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/flit_injector.sv
// ============================================================================
// Module   : flit_injector
// Purpose  : Buffered packet injector. Accepts flits over valid/ready, buffers
//            them, and drives a credit-based NoC injection port while tracking
//            packet framing (header, size, payload) to report completions.
// Ports    : clk_i        clock
//            rst_i        synchronous active-high reset
//            src_valid_i  upstream flit valid
//            src_ready_o  buffer can accept a flit this cycle
//            src_data_i   upstream flit
//            tx_o         flit valid towards the NoC port
//            credit_i     NoC port accepts a flit this cycle
//            data_o       flit towards the NoC port
//            busy_o       packet in progress or buffer non-empty
//            pkt_sent_o   pulse while the last flit of a packet transfers
//            pkt_count_o  packets fully injected since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_injector
    import PhiversPkg::*;
#(
    parameter int unsigned FLIT_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 pkt_sent_o,
    output logic [31:0]          pkt_count_o
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FLIT_SIZE-1:0] fifo_head;
    logic                 push;
    logic                 xfer;

    inj_state_t           state_q, state_d;
    logic [FLIT_SIZE-1:0] remaining_q, remaining_d;
    logic [31:0]          count_q, count_d;

    // Handshakes are masked during reset so that nothing is accepted and a
    // partially sent packet can never produce a completion pulse.
    assign src_ready_o = !fifo_full && !rst_i;
    assign push        = src_valid_i && src_ready_o;
    assign tx_o        = !fifo_empty && !rst_i;
    assign xfer        = tx_o && credit_i;
    assign data_o      = tx_o ? fifo_head : '0;
    assign busy_o      = (state_q != INJ_HEADER) || !fifo_empty;
    assign pkt_count_o = count_q;

    flit_fifo #(
        .FLIT_SIZE  (FLIT_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (src_data_i),
        .pop_i   (xfer),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INJ_HEADER;
            remaining_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
        end
    end

    // The framing FSM only moves when a flit actually leaves the buffer.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        pkt_sent_o  = 1'b0;
        case (state_q)
            INJ_HEADER: begin
                if (xfer) begin
                    state_d = INJ_SIZE;
                end
            end
            INJ_SIZE: begin
                if (xfer) begin
                    if (fifo_head == '0) begin
                        // Header-plus-size packet: the size flit closes it.
                        state_d    = INJ_HEADER;
                        pkt_sent_o = 1'b1;
                        count_d    = count_q + 32'd1;
                    end else begin
                        state_d     = INJ_PAYLOAD;
                        remaining_d = fifo_head;
                    end
                end
            end
            INJ_PAYLOAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == FLIT_SIZE'(1)) begin
                        state_d    = INJ_HEADER;
                        pkt_sent_o = 1'b1;
                        count_d    = count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = INJ_HEADER;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_flit_injector.sv
`default_nettype none

module tb_flit_injector;

    localparam int unsigned FLIT_SIZE  = 32;
    localparam int unsigned FIFO_DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        src_valid_i = 1'b0;
    logic        src_ready_o;
    logic [31:0] src_data_i = '0;
    logic        tx_o;
    logic        credit_i = 1'b0;
    logic [31:0] data_o;
    logic        busy_o;
    logic        pkt_sent_o;
    logic [31:0] pkt_count_o;

    flit_injector #(
        .FLIT_SIZE  (FLIT_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .tx_o        (tx_o),
        .credit_i    (credit_i),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .pkt_sent_o  (pkt_sent_o),
        .pkt_count_o (pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: buffered flits in order, position inside the current
    // packet (0 = header, 1 = size, ...) and the packet length once known.
    logic [31:0]  mq[$];
    longint       pos;
    longint       plen;
    int unsigned  mcount;

    int tests = 0;
    int fails = 0;
    bit tog   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        pos    = 0;
        plen   = 0;
        mcount = 0;
    endfunction

    // One clock cycle: drive inputs (at negedge), check combinational and
    // registered outputs against the model, then advance the model at posedge.
    task automatic step(input logic v, input logic [31:0] d, input logic c, output bit acc);
        logic        e_ready, e_tx, e_sent;
        logic [31:0] e_data;
        longint      tot;
        src_valid_i = v;
        src_data_i  = d;
        credit_i    = c;
        #1;
        e_ready = (mq.size() < FIFO_DEPTH);
        e_tx    = (mq.size() > 0);
        e_data  = e_tx ? mq[0] : 32'h0;
        tot     = (pos == 1 && e_tx) ? 2 + longint'(mq[0]) : plen;
        e_sent  = e_tx && c && pos >= 1 && (pos + 1 == tot);
        chk("src_ready", {31'b0, src_ready_o}, {31'b0, e_ready});
        chk("tx", {31'b0, tx_o}, {31'b0, e_tx});
        chk("data", data_o, e_data);
        chk("busy", {31'b0, busy_o}, {31'b0, (pos != 0) || e_tx});
        chk("pkt_sent", {31'b0, pkt_sent_o}, {31'b0, e_sent});
        chk("pkt_count", pkt_count_o, mcount);
        acc = v && e_ready;
        @(posedge clk_i);
        if (e_tx && c) begin
            if (pos == 1) plen = tot;
            if (e_sent) begin
                pos = 0;
                mcount++;
            end else begin
                pos++;
            end
            void'(mq.pop_front());
        end
        if (acc) mq.push_back(d);
        @(negedge clk_i);
    endtask

    // mode: 0/1 fixed credit, 2 toggling credit.
    function automatic logic cred(input int mode);
        if (mode == 2) begin
            tog = ~tog;
            return tog;
        end
        return mode[0];
    endfunction

    task automatic send(input logic [31:0] d, input int mode);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 40) begin
            step(1'b1, d, cred(mode), acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int mode);
        bit acc;
        int n = 0;
        while (mq.size() > 0 && n < 60) begin
            step(1'b0, $urandom, cred(mode), acc);
            n++;
        end
        if (mq.size() > 0) chk("drain_timeout", mq.size(), 32'd0);
        step(1'b0, 32'h0, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        src_valid_i = 1'b1;
        credit_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data_i = $urandom;
            @(posedge clk_i);
            @(negedge clk_i);
            chk("rst_tx", {31'b0, tx_o}, 32'd0);
            chk("rst_ready", {31'b0, src_ready_o}, 32'd0);
            chk("rst_sent", {31'b0, pkt_sent_o}, 32'd0);
            chk("rst_busy", {31'b0, busy_o}, 32'd0);
            chk("rst_count", pkt_count_o, 32'd0);
            chk("rst_data", data_o, 32'd0);
        end
        rst_i       = 1'b0;
        src_valid_i = 1'b0;
        model_clear();
    endtask

    initial begin
        bit          acc;
        int          naccepted;
        int unsigned c0;
        logic [31:0] src[$];

        model_clear();
        @(negedge clk_i);

        // 1: reset with valid held high
        do_reset();

        // 2: basic packet, size 2
        send(32'h0101, 1);
        chk("t2_tx_after_push", {31'b0, tx_o}, 32'd1);
        send(32'h2, 1);
        send(32'hA, 1);
        send(32'hB, 1);
        drain(1);
        chk("t2_count", pkt_count_o, 32'd1);

        // 3: size-0 packet
        send(32'h0202, 1);
        send(32'h0, 1);
        drain(1);
        chk("t3_count", pkt_count_o, 32'd2);
        chk("t3_busy", {31'b0, busy_o}, 32'd0);

        // 4: fill with credit held low; ninth flit must be refused
        naccepted = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i == 0) ? 32'h0404 : (i == 1) ? 32'd7 : 32'h400 + i, 1'b0, acc);
            if (acc) naccepted++;
        end
        chk("t4_accepted", naccepted, 32'd8);
        chk("t4_ready_full", {31'b0, src_ready_o}, 32'd0);
        send(32'h408, 1);
        drain(1);
        chk("t4_count", pkt_count_o, 32'd3);

        // 5: back-to-back size 1 and size 3 with toggling credit
        c0 = pkt_count_o;
        send(32'h0505, 2); send(32'd1, 2); send(32'h51, 2);
        send(32'h0506, 2); send(32'd3, 2); send(32'h61, 2); send(32'h62, 2); send(32'h63, 2);
        drain(2);
        chk("t5_count", pkt_count_o, c0 + 2);

        // 6: reset after two payload flits of a size-5 packet
        send(32'h0606, 1); send(32'd5, 1); send(32'h71, 1); send(32'h72, 1);
        drain(1);
        chk("t6_busy_mid", {31'b0, busy_o}, 32'd1);
        do_reset();
        send(32'h0707, 1); send(32'd1, 1); send(32'h81, 1);
        drain(1);
        chk("t6_count", pkt_count_o, 32'd1);

        // Randomized traffic: random packet sizes, valid gaps and credit.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (src.size() == 0) begin
                int unsigned sz = $urandom_range(0, 4);
                src.push_back($urandom);
                src.push_back(sz);
                for (int k = 0; k < int'(sz); k++) src.push_back($urandom);
            end
            step(($urandom % 4) != 0, src[0], ($urandom % 3) != 0, acc);
            if (acc) void'(src.pop_front());
        end
        while (src.size() > 0) begin
            send(src[0], 1);
            void'(src.pop_front());
        end
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
